// File: rtl/dotprod.sv
// Dot product of two fixed 16-entry tables over n elements, with the index wrapping mod 16.
// Result appears n+2 edges after reset release and then holds; no handshake, return_val reads 0 until DONE.
module dotprod (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] n,
  output logic [31:0] return_val
);

  typedef enum logic [1:0] {IDLE, LOOP, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] i_reg, i_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] n_reg, n_nxt;
  logic [31:0] ret_nxt;

  logic [3:0]  idx;
  logic [31:0] a_val, b_val, prod;

  // Table entries are affine in the index: A[k] = k+1, B[k] = 16-k.
  assign idx   = i_reg[3:0];
  assign a_val = {28'd0, idx} + 32'd1;
  assign b_val = 32'd16 - {28'd0, idx};
  assign prod  = a_val * b_val;

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state      <= IDLE;
      i_reg      <= '0;
      acc        <= '0;
      n_reg      <= '0;
      return_val <= '0;
    end else begin
      state      <= state_nxt;
      i_reg      <= i_nxt;
      acc        <= acc_nxt;
      n_reg      <= n_nxt;
      return_val <= ret_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i_reg;
    acc_nxt   = acc;
    n_nxt     = n_reg;
    ret_nxt   = return_val;
    case (state)
      IDLE: begin
        n_nxt     = n;
        i_nxt     = '0;
        acc_nxt   = '0;
        state_nxt = LOOP;
      end
      LOOP: begin
        // Exit at i == n_reg, so i never wraps even for n = 2^32-1.
        if (i_reg < n_reg) begin
          acc_nxt = acc + prod;
          i_nxt   = i_reg + 32'd1;
        end else begin
          ret_nxt   = acc;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dotprod.sv
// Randomized scoreboard bench for dotprod: per-cycle expected return_val queued by stimulus,
// popped and compared by an independent monitor on the falling edge.
module tb_dotprod;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [31:0] n;
  logic [31:0] return_val;

  dotprod dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .n          (n),
    .return_val (return_val)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] exp;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: edges seen since reset release and the n captured on the first one.
  logic        rst_prev = 1'b1;
  logic [31:0] n_prev   = '0;
  longint      edges    = 0;
  logic [31:0] n_lat    = '0;
  int          cur_tag  = 0;

  function automatic logic [31:0] dot_ref(input logic [31:0] cnt);
    longint s = 0;
    for (longint k = 0; k < longint'(cnt); k++) begin
      longint m = k % 16;
      s += (m + 1) * (16 - m);
    end
    return s[31:0];
  endfunction

  // Advance one clock with the given inputs applied just after the rising edge.
  task automatic step(input logic rst_v, input logic [31:0] n_v);
    exp_t e;
    @(posedge sys_clk);
    #2;
    if (!rst_prev) begin
      edges++;
      if (edges == 1) n_lat = n_prev;
    end
    sys_rst_n = rst_v;
    n         = n_v;
    if (rst_v) edges = 0;
    rst_prev = rst_v;
    n_prev   = n_v;
    e.tag = cur_tag;
    if (rst_v || edges < longint'(n_lat) + 2) e.exp = '0;
    else                                       e.exp = dot_ref(n_lat);
    q.push_back(e);
  endtask

  task automatic run(input logic rst_v, input logic [31:0] n_v, input int cyc);
    for (int c = 0; c < cyc; c++) step(rst_v, n_v);
  endtask

  always @(negedge sys_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (return_val !== e.exp)
        $display("FAIL ret_val test%0d t=%0t: got %0d expected %0d", e.tag, $time, return_val, e.exp);
      else
        passed++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dir_n [5];
    dir_n[0] = 32'd10; dir_n[1] = 32'd0; dir_n[2] = 32'd1;
    dir_n[3] = 32'd16; dir_n[4] = 32'd17;
    sys_rst_n = 1'b1;
    n         = '0;
    run(1'b1, 32'd0, 3);

    // Directed lengths: 550, 0, 16, 816, 832; long hold after DONE.
    for (int t = 0; t < 5; t++) begin
      cur_tag = t;
      run(1'b1, dir_n[t], 2);
      run(1'b0, dir_n[t], int'(dir_n[t]) + 8);
    end

    // n changed during LOOP has no effect.
    cur_tag = 10;
    run(1'b1, 32'd10, 2);
    run(1'b0, 32'd10, 3);
    run(1'b0, 32'd3, 14);

    // Reset mid-LOOP aborts, then a fresh run with n = 2 gives 46.
    cur_tag = 11;
    run(1'b1, 32'd10, 2);
    run(1'b0, 32'd10, 5);
    run(1'b1, 32'd2, 3);
    run(1'b0, 32'd2, 8);

    // Reset in DONE clears the output immediately.
    cur_tag = 12;
    run(1'b0, 32'd5, 1);
    run(1'b1, 32'd5, 2);
    run(1'b0, 32'd5, 10);

    // Huge n: stays in LOOP reading 0.
    cur_tag = 13;
    run(1'b1, 32'hFFFF_FFFF, 2);
    run(1'b0, 32'hFFFF_FFFF, 30);

    // Randomized lengths, mid-run n disturbance and reset lengths.
    for (int t = 0; t < 14; t++) begin
      int nv;
      int len;
      cur_tag = 20 + t;
      nv  = $urandom_range(0, 40);
      len = nv + 2 + $urandom_range(1, 6);
      run(1'b1, $urandom_range(0, 50), $urandom_range(1, 3));
      step(1'b0, nv);
      step(1'b0, nv);
      for (int c = 2; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, $urandom);
        else                           step(1'b0, nv);
      end
    end

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge sys_clk);
    @(posedge sys_clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
